id_operand_stage: RTL and testbench

Decode/operand-fetch stage directly upstream of the execute ALU. It accepts one 32-bit RV32I instruction per handshake and decodes ADD/SUB/AND/OR and ADDI/ANDI/ORI. It reads an internal 32x32 register file and selects rs2 or the sign-extended immediate. It then registers a1, mux_scr2 and alu_sel for the ALU, plus rd/rd_wen for writeback. The block has a writeback write port, same-cycle writeback bypass, and a busy-bit scoreboard that stalls issue on RAW hazards.

---
 rtl/id_operand_if.sv | 25 ++
 rtl/id_operand_stage.sv | 67 ++++++
 tb/tb_id_operand_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/id_operand_if.sv
// id_operand_if: instruction-in, operand-bundle-out and writeback signals of the decode/operand stage.
interface id_operand_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] a1;
  logic [XLEN-1:0] mux_scr2;
  logic [1:0]      alu_sel;
  logic [4:0]      rd;
  logic            rd_wen;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            illegal_instr;
  modport master (
    output in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, a1, mux_scr2, alu_sel, rd, rd_wen, illegal_instr
  );
  modport slave (
    input  in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, a1, mux_scr2, alu_sel, rd, rd_wen, illegal_instr
  );
endinterface

// File: rtl/id_operand_stage.sv
// id_operand_stage: RV32I add/sub/and/or(+imm) decode, regfile read with wb bypass, RAW scoreboard.
module id_operand_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic         clk,
  input logic         rst_n,
  id_operand_if.slave bus
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rdi;
  logic is_r, is_i, legal, wb_hit, stall, accept, load;
  logic [1:0] sel;
  logic [NREG-1:0] busy, busy_eff, busy_nxt;
  logic [XLEN-1:0] rf [NREG];
  logic [XLEN-1:0] op1, op2;
  assign opc = bus.instr[6:0];
  assign rdi = bus.instr[11:7];
  assign f3  = bus.instr[14:12];
  assign rs1 = bus.instr[19:15];
  assign rs2 = bus.instr[24:20];
  assign f7  = bus.instr[31:25];
  always_comb begin
    is_r     = opc == 7'b0110011;
    is_i     = opc == 7'b0010011;
    legal    = (is_r && ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110)) ||
                         (f7 == 7'b0100000 && f3 == 3'b000))) ||
               (is_i && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110));
    sel      = f3 == 3'b000 ? {1'b0, is_r && f7[5]} : {1'b1, ~f3[0]};
    wb_hit   = bus.wb_en && bus.wb_addr != 5'd0;
    // a busy bit being cleared by this cycle's writeback no longer blocks issue
    busy_eff = busy & ~(wb_hit ? NREG'(1) << bus.wb_addr : '0);
    stall    = legal && (busy_eff[rs1] || (is_r && busy_eff[rs2]));
    bus.in_ready = !stall && (!bus.out_valid || bus.out_ready);
    accept   = bus.in_valid && bus.in_ready;
    load     = accept && legal;
    busy_nxt = busy_eff | (load && rdi != 5'd0 ? NREG'(1) << rdi : '0);
    op1      = rs1 == 5'd0 ? '0 : bus.wb_en && bus.wb_addr == rs1 ? bus.wb_data : rf[rs1];
    op2      = !is_r ? {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]} :
               rs2 == 5'd0 ? '0 : bus.wb_en && bus.wb_addr == rs2 ? bus.wb_data : rf[rs2];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid     <= 1'b0;
      bus.a1            <= '0;
      bus.mux_scr2      <= '0;
      bus.alu_sel       <= 2'b00;
      bus.rd            <= 5'd0;
      bus.rd_wen        <= 1'b0;
      bus.illegal_instr <= 1'b0;
      busy              <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (wb_hit) rf[bus.wb_addr] <= bus.wb_data;
      busy              <= busy_nxt;
      bus.illegal_instr <= accept && !legal;
      bus.out_valid     <= load || (bus.out_valid && !bus.out_ready);
      if (load) begin
        bus.a1       <= op1;
        bus.mux_scr2 <= op2;
        bus.alu_sel  <= sel;
        bus.rd       <= rdi;
        bus.rd_wen   <= rdi != 5'd0;
      end
    end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed sequence with a scoreboard of expected ALU bundles.
module tb_id_operand_stage;
  typedef struct {
    logic [31:0] a1;
    logic [31:0] s2;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;
  logic clk, rst_n;
  int compared = 0, mism = 0;
  exp_t sb [$];
  id_operand_if #(.XLEN(32)) bus ();
  id_operand_stage #(.XLEN(32), .NREG(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] s, input logic [1:0] l,
                              input logic [4:0] r, input logic w);
    exp_t e;
    e.a1 = a; e.s2 = s; e.sel = l; e.rd = r; e.wen = w;
    return e;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] i, input exp_t e);
    bus.instr    = i;
    bus.in_valid = 1'b1;
    sb.push_back(e);
  endtask
  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    tick;
    bus.wb_en = 1'b0;
  endtask
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("a1", bus.a1, e.a1);
        check("mux_scr2", bus.mux_scr2, e.s2);
        check("alu_sel", {30'd0, bus.alu_sel}, {30'd0, e.sel});
        check("rd", {27'd0, bus.rd}, {27'd0, e.rd});
        check("rd_wen", {31'd0, bus.rd_wen}, {31'd0, e.wen});
      end
    end
  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.instr = 32'd0; bus.out_ready = 1'b1;
    bus.wb_en = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
    repeat (3) tick;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_a1", bus.a1, 32'd0);
    check("rst_alu_sel", {30'd0, bus.alu_sel}, 32'd0);
    check("rst_illegal", {31'd0, bus.illegal_instr}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick;
    wb(5'd1, 32'd2);
    wb(5'd2, 32'd1);
    // add x3,x1,x2 then sub x3,x1,x2 back to back
    send(32'h002081B3, mk(32'd2, 32'd1, 2'b00, 5'd3, 1'b1));
    @(negedge clk);
    check("add_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick;
    send(32'h402081B3, mk(32'd2, 32'd1, 2'b01, 5'd3, 1'b1));
    @(negedge clk);
    check("sub_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick;
    // backpressure with addi x5,x1,-1 pending
    bus.out_ready = 1'b0;
    send(32'hFFF08293, mk(32'd2, 32'hFFFFFFFF, 2'b00, 5'd5, 1'b1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_a1", bus.a1, 32'd2);
      check("bp_mux_scr2", bus.mux_scr2, 32'd1);
      check("bp_alu_sel", {30'd0, bus.alu_sel}, 32'd1);
      tick;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick;
    bus.in_valid = 1'b0;
    tick;
    @(negedge clk);
    check("clear_out_valid", {31'd0, bus.out_valid}, 32'd0);
    tick;
    // and x6,x3,x1 stalls on busy x3 until writeback of x3
    send(32'h0011F333, mk(32'd3, 32'd2, 2'b10, 5'd6, 1'b1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("raw_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("raw_out_valid", {31'd0, bus.out_valid}, 32'd0);
      tick;
    end
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'd3;
    @(negedge clk);
    check("raw_wb_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick;
    bus.wb_en = 1'b0; bus.in_valid = 1'b0;
    tick;
    tick;
    // mul encoding is illegal
    bus.instr = 32'h02000033; bus.in_valid = 1'b1;
    @(negedge clk);
    check("ill_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("ill_pulse", {31'd0, bus.illegal_instr}, 32'd1);
    check("ill_out_valid", {31'd0, bus.out_valid}, 32'd0);
    tick;
    @(negedge clk);
    check("ill_pulse_end", {31'd0, bus.illegal_instr}, 32'd0);
    wb(5'd0, 32'h0000DEAD);
    // ori x0,x0,5 then add x8,x0,x0: rd=0 sets no busy bit
    send(32'h00506013, mk(32'd0, 32'd5, 2'b11, 5'd0, 1'b0));
    @(negedge clk);
    check("ori_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick;
    send(32'h00000433, mk(32'd0, 32'd0, 2'b00, 5'd8, 1'b1));
    @(negedge clk);
    check("x0_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick;
    bus.in_valid = 1'b0;
    tick;
    tick;
    // reset while and x9,x1,x2 is held on the output
    bus.out_ready = 1'b0;
    bus.instr = 32'h0020F4B3; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_a1", bus.a1, 32'd0);
    check("async_alu_sel", {30'd0, bus.alu_sel}, 32'd0);
    tick;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    send(32'h00148533, mk(32'd0, 32'd0, 2'b00, 5'd10, 1'b1));
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick;
    bus.in_valid = 1'b0;
    tick;
    tick;
    check("sb_left", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
